// File: rtl/vliw_fetch_pkg.sv
// rtl/vliw_fetch_pkg.sv - shared widths and fetch FSM encodings for the VLIW front end
package vliw_fetch_pkg;

    localparam int DEF_BUNDLE_W = 1024;
    localparam int DEF_ADDR_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/vliw_fetch_fifo.sv
// rtl/vliw_fetch_fifo.sv - small synchronous FIFO holding {pc, bundle} entries
module vliw_fetch_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [CW-1:0] o_count,
    output logic [W-1:0]  o_head
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage is reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/vliw_fetch.sv
// rtl/vliw_fetch.sv - instruction fetch front end: credit-limited requests, bundle buffer, redirect flush
module vliw_fetch
    import vliw_fetch_pkg::*;
#(
    parameter int                BUNDLE_W = DEF_BUNDLE_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_redirect_valid,
    input  logic [ADDR_W-1:0]   i_redirect_pc,
    output logic                o_mem_req_valid,
    input  logic                i_mem_req_ready,
    output logic [ADDR_W-1:0]   o_mem_req_addr,
    input  logic                i_mem_rsp_valid,
    input  logic [BUNDLE_W-1:0] i_mem_rsp_data,
    output logic                o_bnd_valid,
    input  logic                i_bnd_ready,
    output logic [BUNDLE_W-1:0] o_bnd_data,
    output logic [ADDR_W-1:0]   o_bnd_pc
);

    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]    L_DEPTH = (CW + 1)'(DEPTH);

    fetch_state_t               r_state;
    fetch_state_t               w_state_next;
    logic [ADDR_W-1:0]          r_fetch_pc;
    logic [ADDR_W-1:0]          r_rsp_pc;
    logic [CW-1:0]              r_outstanding;
    logic [CW-1:0]              r_discard_cnt;
    logic [CW-1:0]              w_out_next;
    logic [CW-1:0]              w_disc_next;
    logic [CW-1:0]              w_fifo_count;
    logic [CW:0]                w_inflight;
    logic                       w_fire;
    logic                       w_push;
    logic                       w_pop;
    logic [ADDR_W+BUNDLE_W-1:0] w_head;

    // Credits count buffered plus in-flight bundles from registered state only.
    assign w_inflight      = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
    assign o_mem_req_valid = (r_state == ST_RUN) && !i_redirect_valid && (w_inflight < L_DEPTH);
    assign o_mem_req_addr  = r_fetch_pc;
    assign w_fire          = o_mem_req_valid && i_mem_req_ready;
    assign w_push          = i_mem_rsp_valid && !i_redirect_valid && (r_discard_cnt == '0);
    assign o_bnd_valid     = (w_fifo_count != '0) && !i_redirect_valid;
    assign w_pop           = o_bnd_valid && i_bnd_ready;
    assign o_bnd_pc        = w_head[ADDR_W+BUNDLE_W-1 -: ADDR_W];
    assign o_bnd_data      = w_head[BUNDLE_W-1:0];

    always_comb begin
        w_out_next = r_outstanding;
        if (w_fire) begin
            w_out_next = w_out_next + 1'b1;
        end
        if (i_mem_rsp_valid) begin
            w_out_next = w_out_next - 1'b1;
        end
    end

    // A response landing in the redirect cycle is already dropped, so it is not owed.
    always_comb begin
        w_disc_next = r_discard_cnt;
        if (i_redirect_valid) begin
            w_disc_next = r_outstanding - CW'(i_mem_rsp_valid);
        end else if (i_mem_rsp_valid && (r_discard_cnt != '0)) begin
            w_disc_next = r_discard_cnt - 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_redirect_valid) begin
            w_state_next = (w_disc_next == '0) ? ST_RUN : ST_FLUSH;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_next = ST_RUN;
                ST_RUN:   w_state_next = ST_RUN;
                ST_FLUSH: w_state_next = (w_disc_next == '0) ? ST_RUN : ST_FLUSH;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard_cnt <= '0;
        end else begin
            r_outstanding <= w_out_next;
            r_discard_cnt <= w_disc_next;
            if (i_redirect_valid) begin
                r_fetch_pc <= i_redirect_pc;
                r_rsp_pc   <= i_redirect_pc;
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= r_fetch_pc + 1'b1;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + 1'b1;
                end
            end
        end
    end

    vliw_fetch_fifo #(
        .W     (ADDR_W + BUNDLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data ({r_rsp_pc, i_mem_rsp_data}),
        .i_pop       (w_pop),
        .i_flush     (i_redirect_valid),
        .o_count     (w_fifo_count),
        .o_head      (w_head)
    );

endmodule

// File: tb/tb_vliw_fetch.sv
// tb/tb_vliw_fetch.sv - randomized bench for vliw_fetch against an epoch-tagged queue model
module tb_vliw_fetch;

    localparam int             BW    = 1024;
    localparam int             AW    = 16;
    localparam int             DEPTH = 4;
    localparam logic [AW-1:0]  RPC   = 16'h0010;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic [BW-1:0] rsp_data;
    logic          bnd_valid;
    logic          bnd_ready;
    logic [BW-1:0] bnd_data;
    logic [AW-1:0] bnd_pc;

    always #5 clk = ~clk;

    vliw_fetch #(
        .BUNDLE_W (BW),
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_mem_req_valid  (req_valid),
        .i_mem_req_ready  (req_ready),
        .o_mem_req_addr   (req_addr),
        .i_mem_rsp_valid  (rsp_valid),
        .i_mem_rsp_data   (rsp_data),
        .o_bnd_valid      (bnd_valid),
        .i_bnd_ready      (bnd_ready),
        .o_bnd_data       (bnd_data),
        .o_bnd_pc         (bnd_pc)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        int unsigned   epoch;
        int unsigned   due;
    } mreq_t;

    mreq_t         mem_q[$];
    logic [AW-1:0] fifo_q[$];
    logic [AW-1:0] issued_q[$];
    logic [AW-1:0] popped_q[$];
    int unsigned   epoch = 0;
    int unsigned   cyc = 0;
    logic [AW-1:0] exp_fetch_pc;
    bit            idle_cycle;
    int            lat = 1;
    bit            lat_rand = 0;
    bit            req_rand = 0;
    int            bndr_mode = 1;
    bit            chk_cont = 0;
    bit            got_pop;
    bit            got_fire;
    logic          last_bnd_valid;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (low 64 bits)", tag, got[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [BW-1:0] bundle_of(input logic [AW-1:0] a);
        logic [BW-1:0] d;
        for (int i = 0; i < BW / 32; i++) begin
            d[i*32 +: 32] = {a, 16'(i) ^ 16'hA5C3};
        end
        return d;
    endfunction

    function automatic int old_count();
        int n = 0;
        foreach (mem_q[i]) begin
            if (mem_q[i].epoch != epoch) n++;
        end
        return n;
    endfunction

    task automatic step(input bit redir, input logic [AW-1:0] rpc);
        bit    exp_req;
        bit    exp_bnd;
        bit    rsp;
        bit    fire;
        bit    pop;
        bit    full;
        mreq_t r;
        int    d;
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc    = rpc;
        req_ready      = req_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        bnd_ready      = (bndr_mode == 0) ? 1'b0 : (bndr_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        rsp            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        rsp_valid      = rsp;
        rsp_data       = rsp ? bundle_of(mem_q[0].addr) : '0;
        #1;
        exp_req = !idle_cycle && (old_count() == 0) && !redir && (mem_q.size() + fifo_q.size() < DEPTH);
        exp_bnd = (fifo_q.size() > 0) && !redir;
        last_bnd_valid = bnd_valid;
        check("req_valid", BW'(req_valid), BW'(exp_req));
        check("bnd_valid", BW'(bnd_valid), BW'(exp_bnd));
        if (exp_req) check("req_addr", BW'(req_addr), BW'(exp_fetch_pc));
        if (exp_bnd) begin
            check("bnd_pc", BW'(bnd_pc), BW'(fifo_q[0]));
            check("bnd_data", bnd_data, bundle_of(fifo_q[0]));
        end
        if (chk_cont && got_pop) check("stream_bnd_cont", BW'(bnd_valid), BW'(1'b1));
        if (chk_cont && got_fire) check("stream_req_cont", BW'(req_valid), BW'(1'b1));
        fire = exp_req && req_ready;
        pop  = exp_bnd && bnd_ready;
        full = (fifo_q.size() >= DEPTH);
        if (pop) begin
            popped_q.push_back(bnd_pc);
            void'(fifo_q.pop_front());
            got_pop = 1;
        end
        if (rsp) begin
            r = mem_q.pop_front();
            if (!redir && r.epoch == epoch) begin
                check("fifo_overflow", BW'(full), BW'(1'b0));
                fifo_q.push_back(r.addr);
            end
        end
        if (redir) begin
            fifo_q.delete();
            epoch++;
            exp_fetch_pc = rpc;
        end
        if (fire) begin
            d = lat_rand ? int'($urandom_range(1, 4)) : lat;
            mem_q.push_back('{addr: exp_fetch_pc, epoch: epoch, due: cyc + d});
            issued_q.push_back(req_addr);
            exp_fetch_pc = exp_fetch_pc + 1'b1;
            got_fire = 1;
        end
        idle_cycle = 0;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        bnd_ready      = 1'b0;
        mem_q.delete();
        fifo_q.delete();
        issued_q.delete();
        popped_q.delete();
        exp_fetch_pc = RPC;
        idle_cycle   = 1;
        repeat (2) @(negedge clk);
        check("rst_req_valid", BW'(req_valid), BW'(1'b0));
        check("rst_bnd_valid", BW'(bnd_valid), BW'(1'b0));
        check("rst_req_addr", BW'(req_addr), BW'(RPC));
        check("rst_bnd_data", bnd_data, '0);
        check("rst_bnd_pc", BW'(bnd_pc), '0);
        check("rst_fifo_count", BW'(dut.w_fifo_count), '0);
        check("rst_outstanding", BW'(dut.r_outstanding), '0);
        check("rst_discard", BW'(dut.r_discard_cnt), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int n;
        do_reset();

        // Streaming from RESET_PC with a 1-cycle memory.
        got_pop = 0; got_fire = 0; chk_cont = 1;
        repeat (30) step(1'b0, '0);
        chk_cont = 0;
        check("stream_first_req", BW'(issued_q[0]), BW'(RPC));
        check("stream_first_bnd", BW'(popped_q[0]), BW'(RPC));

        // Backpressure: consumer stalls, buffer fills to its depth.
        bndr_mode = 0;
        repeat (10) step(1'b0, '0);
        check("bp_held", BW'(dut.w_fifo_count), BW'(DEPTH));
        bndr_mode = 1;
        repeat (20) step(1'b0, '0);

        // Redirect with requests in flight on a 3-cycle memory.
        lat = 3;
        n = 0;
        while (mem_q.size() < 2 && n < 20) begin step(1'b0, '0); n++; end
        popped_q.delete();
        step(1'b1, 16'h0200);
        n = old_count();
        @(posedge clk); #1;
        check("redir_discard", BW'(dut.r_discard_cnt), BW'(n));
        check("redir_fifo_empty", BW'(dut.w_fifo_count), '0);
        repeat (20) step(1'b0, '0);
        check("redir_first_pc", BW'(popped_q.size() > 0 ? popped_q[0] : 16'hDEAD), BW'(16'h0200));

        // Redirect landing on a response and a would-be pop.
        lat = 2;
        n = 0;
        while (!(fifo_q.size() > 0 && mem_q.size() > 0 && mem_q[0].due <= cyc) && n < 50) begin
            step(1'b0, '0); n++;
        end
        step(1'b1, 16'h0300);
        check("coinc_no_pop", BW'(last_bnd_valid), BW'(1'b0));
        n = old_count();
        @(posedge clk); #1;
        check("coinc_discard", BW'(dut.r_discard_cnt), BW'(n));
        repeat (15) step(1'b0, '0);

        // Address wrap at the top of the bundle space.
        lat = 1;
        repeat (5) step(1'b0, '0);
        step(1'b1, 16'hFFFE);
        issued_q.delete();
        popped_q.delete();
        repeat (15) step(1'b0, '0);
        check("wrap_req_cnt", BW'(issued_q.size() >= 3), BW'(1'b1));
        if (issued_q.size() >= 3) begin
            check("wrap_req0", BW'(issued_q[0]), BW'(16'hFFFE));
            check("wrap_req1", BW'(issued_q[1]), BW'(16'hFFFF));
            check("wrap_req2", BW'(issued_q[2]), BW'(16'h0000));
        end
        check("wrap_bnd_cnt", BW'(popped_q.size() >= 3), BW'(1'b1));
        if (popped_q.size() >= 3) begin
            check("wrap_bnd0", BW'(popped_q[0]), BW'(16'hFFFE));
            check("wrap_bnd1", BW'(popped_q[1]), BW'(16'hFFFF));
            check("wrap_bnd2", BW'(popped_q[2]), BW'(16'h0000));
        end

        // Random traffic with random latency, backpressure and redirects.
        lat_rand = 1; req_rand = 1; bndr_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                step(1'b1, ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom));
            end else begin
                step(1'b0, '0);
            end
        end

        // Asynchronous reset while flushing.
        lat_rand = 0; req_rand = 0; bndr_mode = 1; lat = 4;
        repeat (3) step(1'b0, '0);
        n = 0;
        while (mem_q.size() < 2 && n < 20) begin step(1'b0, '0); n++; end
        step(1'b1, 16'h0400);
        step(1'b0, '0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req_valid", BW'(req_valid), BW'(1'b0));
        check("arst_bnd_valid", BW'(bnd_valid), BW'(1'b0));
        check("arst_req_addr", BW'(req_addr), BW'(RPC));
        do_reset();
        lat = 1;
        repeat (10) step(1'b0, '0);
        check("arst_restart_pc", BW'(issued_q.size() > 0 ? issued_q[0] : 16'hDEAD), BW'(RPC));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
